// File: rtl/lcd_page_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_page_scheduler
//
// Decides which page the shared LCD frame writer shows and when it is
// rewritten. There are three 2x16-character page sources: vitals (page 0),
// cold-storage temperature (page 1) and alarm (page 2). For each frame the
// block latches the chosen page's rows and issues one start pulse. It then
// waits for the writer's completion edge, or gives up after a timeout.
// The display is refreshed periodically. Pages 0 and 1 rotate on a dwell
// timer, and the alarm page preempts rotation while alarm is high.
//
// Ports
//   clk_1MHz                 sole clock, all logic on the rising edge
//   rst_n                    synchronous, active-low reset
//   enable                   scheduler runs while high (ignored during a transfer)
//   page0_row1/page0_row2    vitals page, 16 ASCII chars per row, MSB byte leftmost
//   page1_row1/page1_row2    temperature page, same format
//   alarm_row1/alarm_row2    alarm page, same format
//   page1_en                 page 1 takes part in the rotation when high
//   alarm                    level; selects the alarm page while high
//   frame_done               completion from the frame writer; only its rising
//                            edge counts
//   lcd_row1/lcd_row2        frame snapshot; held from SELECT to the next SELECT
//   frame_start              one-cycle start pulse, high in the first WAIT cycle
//   page_sel                 page currently on the LCD (0, 1 or 2)
//   busy                     high in START and WAIT
//   timeout_err              set on a transfer timeout, cleared by the next
//                            accepted completion
// -----------------------------------------------------------------------------
module lcd_page_scheduler #(
    parameter int DWELL_CYCLES   = 2000000,
    parameter int REFRESH_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         clk_1MHz,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] page0_row1,
    input  logic [127:0] page0_row2,
    input  logic [127:0] page1_row1,
    input  logic [127:0] page1_row2,
    input  logic [127:0] alarm_row1,
    input  logic [127:0] alarm_row2,
    input  logic         page1_en,
    input  logic         alarm,
    input  logic         frame_done,
    output logic [127:0] lcd_row1,
    output logic [127:0] lcd_row2,
    output logic         frame_start,
    output logic [1:0]   page_sel,
    output logic         busy,
    output logic         timeout_err
);

    // Each counter only has to reach PARAM-1, so $clog2(PARAM) bits are
    // enough. The width is kept at one bit or more for degenerate values.
    localparam int DW = (DWELL_CYCLES   > 1) ? $clog2(DWELL_CYCLES)   : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_CYCLES - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] PAGE_ALARM = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_START,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t          state_reg, state_next;
    logic [127:0]    row1_reg, row1_next;
    logic [127:0]    row2_reg, row2_next;
    logic [1:0]      page_sel_reg, page_sel_next;
    logic            ptr_reg, ptr_next;
    logic [DW-1:0]   dwell_reg, dwell_next;
    logic [RW-1:0]   refresh_reg, refresh_next;
    logic [TW-1:0]   timeout_cnt_reg, timeout_cnt_next;
    logic            timeout_err_reg, timeout_err_next;
    logic            frame_start_reg, frame_start_next;
    logic            done_prev_reg;

    logic            done_rise;
    logic            dwell_expired;
    logic            sel_ptr;

    // The blank row (sixteen ASCII spaces) is what the LCD shows out of reset.
    logic [127:0]    blank_row;

    for (genvar gi = 0; gi < 16; gi++) begin : g_blank
        assign blank_row[gi*8 +: 8] = 8'h20;
    end

    // A frame_done that is still high from an earlier frame is not a new
    // completion. Only a low-to-high transition is accepted.
    assign done_rise     = frame_done & ~done_prev_reg;
    assign dwell_expired = (dwell_reg == DWELL_LAST);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            row1_reg        <= blank_row;
            row2_reg        <= blank_row;
            page_sel_reg    <= 2'd0;
            ptr_reg         <= 1'b0;
            dwell_reg       <= '0;
            refresh_reg     <= '0;
            timeout_cnt_reg <= '0;
            timeout_err_reg <= 1'b0;
            frame_start_reg <= 1'b0;
            done_prev_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            row1_reg        <= row1_next;
            row2_reg        <= row2_next;
            page_sel_reg    <= page_sel_next;
            ptr_reg         <= ptr_next;
            dwell_reg       <= dwell_next;
            refresh_reg     <= refresh_next;
            timeout_cnt_reg <= timeout_cnt_next;
            timeout_err_reg <= timeout_err_next;
            frame_start_reg <= frame_start_next;
            done_prev_reg   <= frame_done;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        row1_next        = row1_reg;
        row2_next        = row2_reg;
        page_sel_next    = page_sel_reg;
        ptr_next         = ptr_reg;
        refresh_next     = refresh_reg;
        timeout_cnt_next = timeout_cnt_reg;
        timeout_err_next = timeout_err_reg;
        frame_start_next = 1'b0;
        sel_ptr          = ptr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (alarm) begin
                    // The alarm page leaves the rotation pointer untouched,
                    // so rotation resumes where it stopped.
                    page_sel_next = PAGE_ALARM;
                    row1_next     = alarm_row1;
                    row2_next     = alarm_row2;
                end else begin
                    if (dwell_expired) begin
                        sel_ptr = (!ptr_reg && page1_en);
                    end
                    // Page 1 may have left the rotation while it was on
                    // screen. In that case fall back to page 0 now.
                    if (sel_ptr && !page1_en) begin
                        sel_ptr = 1'b0;
                    end
                    ptr_next      = sel_ptr;
                    page_sel_next = {1'b0, sel_ptr};
                    row1_next     = sel_ptr ? page1_row1 : page0_row1;
                    row2_next     = sel_ptr ? page1_row2 : page0_row2;
                end
                state_next = ST_START;
            end

            ST_START: begin
                // frame_start is registered, so the pulse shows in the first
                // WAIT cycle, one cycle after the rows are already stable.
                frame_start_next = 1'b1;
                timeout_cnt_next = '0;
                state_next       = ST_WAIT;
            end

            ST_WAIT: begin
                if (done_rise) begin
                    timeout_err_next = 1'b0;
                    refresh_next     = '0;
                    state_next       = ST_HOLD;
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    timeout_err_next = 1'b1;
                    refresh_next     = '0;
                    state_next       = ST_HOLD;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + TW'(1);
                end
            end

            ST_HOLD: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (alarm && (page_sel_reg != PAGE_ALARM)) begin
                    state_next = ST_SELECT;
                end else if (!alarm && (page_sel_reg == PAGE_ALARM)) begin
                    state_next = ST_SELECT;
                end else if (refresh_reg == REFRESH_LAST) begin
                    state_next = ST_SELECT;
                end else begin
                    refresh_next = refresh_reg + RW'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Dwell timer. It is held at zero while idle or while the alarm page is
    // forced, so a rotation page always gets a full dwell after an alarm
    // clears. It saturates at the expiry value and is only consumed by the
    // SELECT state, so an expiry during a transfer waits for the next SELECT.
    always_comb begin
        dwell_next = dwell_reg;
        if ((state_reg == ST_IDLE) || alarm) begin
            dwell_next = '0;
        end else if ((state_reg == ST_SELECT) && dwell_expired) begin
            dwell_next = '0;
        end else if (!dwell_expired) begin
            dwell_next = dwell_reg + DW'(1);
        end
    end

    assign lcd_row1    = row1_reg;
    assign lcd_row2    = row2_reg;
    assign frame_start = frame_start_reg;
    assign page_sel    = page_sel_reg;
    assign busy        = (state_reg == ST_START) || (state_reg == ST_WAIT);
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_lcd_page_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lcd_page_scheduler
//
// Directed bench for lcd_page_scheduler with DWELL=20, REFRESH=5, TIMEOUT=8.
// A frame-writer stand-in sees frame_start high in a cycle and raises
// frame_done in the third cycle after it, for one cycle (mode 1). In mode 3 it
// raises frame_done at that point and then holds it high. In mode 0 it stays
// silent. Inputs are driven and outputs sampled on the falling clock edge.
// Negedge n of a test is the n-th falling edge after the falling edge where
// reset was released together with enable.
// -----------------------------------------------------------------------------
module tb_lcd_page_scheduler;

    localparam int DWELL   = 20;
    localparam int REFRESH = 5;
    localparam int TIMEOUT = 8;

    logic         clk_1MHz = 1'b0;
    logic         rst_n    = 1'b0;
    logic         enable   = 1'b0;
    logic [127:0] page0_row1 = "HR:072 SPO2:098 ";
    logic [127:0] page0_row2 = "BP:120/80  T:37C";
    logic [127:0] page1_row1 = "FRIDGE A: +04.1C";
    logic [127:0] page1_row2 = "FRIDGE B: -18.5C";
    logic [127:0] alarm_row1 = "!! ALARM !!     ";
    logic [127:0] alarm_row2 = "CHECK PATIENT   ";
    logic         page1_en   = 1'b0;
    logic         alarm      = 1'b0;
    logic         frame_done = 1'b0;
    logic [127:0] lcd_row1;
    logic [127:0] lcd_row2;
    logic         frame_start;
    logic [1:0]   page_sel;
    logic         busy;
    logic         timeout_err;

    logic [127:0] blank = {16{8'h20}};

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    int resp_mode = 0;
    int cd        = 0;
    logic done_hold = 1'b0;

    int fs_cyc[$];
    int fs_page[$];

    lcd_page_scheduler #(
        .DWELL_CYCLES  (DWELL),
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_1MHz   (clk_1MHz),
        .rst_n      (rst_n),
        .enable     (enable),
        .page0_row1 (page0_row1),
        .page0_row2 (page0_row2),
        .page1_row1 (page1_row1),
        .page1_row2 (page1_row2),
        .alarm_row1 (alarm_row1),
        .alarm_row2 (alarm_row2),
        .page1_en   (page1_en),
        .alarm      (alarm),
        .frame_done (frame_done),
        .lcd_row1   (lcd_row1),
        .lcd_row2   (lcd_row2),
        .frame_start(frame_start),
        .page_sel   (page_sel),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    always @(posedge clk_1MHz) cyc <= cyc + 1;

    // Frame-writer stand-in.
    always @(negedge clk_1MHz) begin : responder
        logic pulse;
        pulse = 1'b0;
        if (resp_mode == 0) begin
            cd        = 0;
            done_hold = 1'b0;
        end else if (frame_start) begin
            cd = 3;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) pulse = 1'b1;
        end
        if (resp_mode == 3 && pulse) done_hold = 1'b1;
        frame_done = (resp_mode == 3) ? done_hold : pulse;
    end

    // Log of every frame start: cycle number and page shown.
    always @(negedge clk_1MHz) begin
        if (frame_start) begin
            fs_cyc.push_back(cyc);
            fs_page.push_back(int'(page_sel));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_1MHz);
    endtask

    // Holds reset for two cycles, then releases it with enable high. On
    // return the bench is at negedge 0 of the test.
    task automatic do_reset(input int mode, input logic p1en, input logic alm);
        @(negedge clk_1MHz);
        rst_n     = 1'b0;
        enable    = 1'b0;
        alarm     = 1'b0;
        resp_mode = 0;
        page1_en  = p1en;
        step(2);
        resp_mode = mode;
        alarm     = alm;
        rst_n     = 1'b1;
        enable    = 1'b1;
        fs_cyc.delete();
        fs_page.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        tests++; if (lcd_row1 !== blank) begin errors++; $display("FAIL reset_row1 got %h need %h", lcd_row1, blank); end
        tests++; if (lcd_row2 !== blank) begin errors++; $display("FAIL reset_row2 got %h need %h", lcd_row2, blank); end
        tests++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b need 0", frame_start); end
        tests++; if (page_sel !== 2'd0) begin errors++; $display("FAIL reset_page_sel got %0d need 0", page_sel); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
        tests++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b need 0", timeout_err); end
        $display("[TB] reset checks done");
    endtask

    task automatic test_first_frame();
        do_reset(1, 1'b0, 1'b0);
        step(1); // SELECT
        tests++; if (busy !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL first_select busy/fs got %b/%b need 0/0", busy, frame_start); end
        step(1); // START
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got %b need 1", busy); end
        tests++; if (lcd_row1 !== page0_row1) begin errors++; $display("FAIL first_row1 got %h need %h", lcd_row1, page0_row1); end
        tests++; if (lcd_row2 !== page0_row2) begin errors++; $display("FAIL first_row2 got %h need %h", lcd_row2, page0_row2); end
        tests++; if (page_sel !== 2'd0 || frame_start !== 1'b0) begin errors++; $display("FAIL first_start page/fs got %0d/%b need 0/0", page_sel, frame_start); end
        step(1); // first WAIT cycle: start pulse
        tests++; if (frame_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL first_pulse fs/busy got %b/%b need 1/1", frame_start, busy); end
        step(1);
        tests++; if (frame_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL first_pulse_end fs/busy got %b/%b need 0/1", frame_start, busy); end
        step(3); // done accepted, HOLD
        tests++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL first_hold busy/terr got %b/%b need 0/0", busy, timeout_err); end
        $display("[TB] first frame: page_sel=%0d row1=\"%s\"", page_sel, lcd_row1);
    endtask

    task automatic test_rotation();
        int exp_page[6] = '{0, 0, 1, 1, 0, 0};
        do_reset(1, 1'b1, 1'b0);
        step(62);
        tests++; if (fs_cyc.size() != 6) begin errors++; $display("FAIL rot_count got %0d need 6", fs_cyc.size()); end
        for (int i = 0; i < 6 && i < fs_cyc.size(); i++) begin
            tests++;
            if (fs_page[i] != exp_page[i]) begin errors++; $display("FAIL rot_page[%0d] got %0d need %0d", i, fs_page[i], exp_page[i]); end
            if (i > 0) begin
                tests++;
                if (fs_cyc[i] - fs_cyc[i-1] != 11) begin errors++; $display("FAIL rot_gap[%0d] got %0d need 11", i, fs_cyc[i] - fs_cyc[i-1]); end
            end
            $display("[TB] rotation frame %0d at cycle %0d page %0d", i, fs_cyc[i], fs_page[i]);
        end
    endtask

    task automatic test_no_page1();
        do_reset(1, 1'b0, 1'b0);
        step(62);
        tests++; if (fs_cyc.size() != 6) begin errors++; $display("FAIL nop1_count got %0d need 6", fs_cyc.size()); end
        for (int i = 0; i < fs_cyc.size(); i++) begin
            tests++;
            if (fs_page[i] != 0) begin errors++; $display("FAIL nop1_page[%0d] got %0d need 0", i, fs_page[i]); end
        end
        $display("[TB] page1 disabled: %0d frames logged", fs_cyc.size());
    endtask

    task automatic test_alarm();
        do_reset(1, 1'b1, 1'b0);
        step(30); // HOLD after the first page-1 frame
        tests++; if (page_sel !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL alarm_pre page/busy got %0d/%b need 1/0", page_sel, busy); end
        alarm = 1'b1;
        step(1); // SELECT
        tests++; if (frame_start !== 1'b0 || page_sel !== 2'd1) begin errors++; $display("FAIL alarm_select fs/page got %b/%0d need 0/1", frame_start, page_sel); end
        step(1); // START
        tests++; if (page_sel !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL alarm_start page/busy got %0d/%b need 2/1", page_sel, busy); end
        tests++; if (lcd_row1 !== alarm_row1) begin errors++; $display("FAIL alarm_row1 got %h need %h", lcd_row1, alarm_row1); end
        step(1);
        tests++; if (frame_start !== 1'b1) begin errors++; $display("FAIL alarm_pulse got %b need 1", frame_start); end
        step(5); // HOLD of the alarm frame
        alarm = 1'b0;
        step(1);
        tests++; if (page_sel !== 2'd2) begin errors++; $display("FAIL alarm_clear_select page got %0d need 2", page_sel); end
        step(1);
        tests++; if (page_sel !== 2'd1 || lcd_row1 !== page1_row1) begin errors++; $display("FAIL alarm_return page got %0d need 1, row1 %h need %h", page_sel, lcd_row1, page1_row1); end
        step(1);
        tests++; if (frame_start !== 1'b1) begin errors++; $display("FAIL alarm_return_pulse got %b need 1", frame_start); end
        step(11);
        tests++; if (frame_start !== 1'b1 || page_sel !== 2'd1) begin errors++; $display("FAIL dwell_restart fs/page got %b/%0d need 1/1", frame_start, page_sel); end
        step(11);
        tests++; if (frame_start !== 1'b1 || page_sel !== 2'd0) begin errors++; $display("FAIL dwell_expire fs/page got %b/%0d need 1/0", frame_start, page_sel); end
        $display("[TB] alarm preempt/return sequence done, page_sel=%0d", page_sel);
    endtask

    task automatic test_timeout();
        do_reset(0, 1'b0, 1'b0);
        step(3);
        tests++; if (frame_start !== 1'b1) begin errors++; $display("FAIL to_pulse got %b need 1", frame_start); end
        step(7);
        tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early terr/busy got %b/%b need 0/1", timeout_err, busy); end
        step(1);
        tests++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_set terr/busy got %b/%b need 1/0", timeout_err, busy); end
        resp_mode = 1;
        step(7);
        tests++; if (frame_start !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_next fs/terr got %b/%b need 1/1", frame_start, timeout_err); end
        step(3);
        tests++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_hold got %b need 1", timeout_err); end
        step(1);
        tests++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_clear terr/busy got %b/%b need 0/0", timeout_err, busy); end
        $display("[TB] timeout set and cleared, timeout_err=%b", timeout_err);
    endtask

    task automatic test_done_held();
        int starts;
        do_reset(3, 1'b0, 1'b1);
        step(6);
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL held_wait busy got %b need 1", busy); end
        step(1);
        tests++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL held_first busy/terr got %b/%b need 0/0", busy, timeout_err); end
        step(7);
        tests++; if (frame_start !== 1'b1) begin errors++; $display("FAIL held_second_pulse got %b need 1", frame_start); end
        step(7);
        tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL held_no_accept terr/busy got %b/%b need 0/1", timeout_err, busy); end
        step(1);
        tests++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL held_timeout got %b need 1", timeout_err); end
        step(7);
        tests++; if (frame_start !== 1'b1 || busy !== 1'b1 || page_sel !== 2'd2) begin errors++; $display("FAIL held_third fs/busy/page got %b/%b/%0d need 1/1/2", frame_start, busy, page_sel); end
        rst_n = 1'b0;
        step(1);
        tests++; if (lcd_row1 !== blank || lcd_row2 !== blank) begin errors++; $display("FAIL midreset_rows got %h/%h need %h", lcd_row1, lcd_row2, blank); end
        tests++; if (page_sel !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL midreset page/busy got %0d/%b need 0/0", page_sel, busy); end
        tests++; if (frame_start !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL midreset fs/terr got %b/%b need 0/0", frame_start, timeout_err); end
        rst_n  = 1'b1;
        enable = 1'b0;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (frame_start === 1'b1 || busy === 1'b1) starts++;
        end
        tests++; if (starts != 0) begin errors++; $display("FAIL midreset_restart got %0d starts need 0", starts); end
        resp_mode = 0;
        alarm     = 1'b0;
        $display("[TB] held done / mid-transfer reset done");
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_rotation();
        test_no_page1();
        test_alarm();
        test_timeout();
        test_done_held();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/lcd_page_scheduler.md
# lcd_page_scheduler

Sequences the shared LCD frame writer, which transfers a 2×16-character frame over the LCD I²C bus and signals completion. The block multiplexes three 32-character page sources: vitals page 0, cold-storage temperature page 1 and alarm page 2. It snapshots the selected page, issues one start pulse per frame and waits for the writer's completion. It also refreshes the display periodically, rotates pages on a dwell timer, and preempts rotation with the alarm page.

## Interface
Parameters:
- DWELL_CYCLES, 2000000, clk_1MHz cycles a rotation page stays selected (2 s)
- REFRESH_CYCLES, 250000, idle cycles between frame rewrites (250 ms)
- TIMEOUT_CYCLES, 100000, maximum cycles to wait for frame completion

Ports:
- clk_1MHz  in  1  sole clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  level; scheduler runs while high
- page0_row1, page0_row2  in  128  vitals page, 16 ASCII chars each, MSB byte = leftmost character
- page1_row1, page1_row2  in  128  temperature page, same format
- alarm_row1, alarm_row2  in  128  alarm page, same format
- page1_en  in  1  page 1 joins the rotation when high
- alarm  in  1  level; selects the alarm page while high
- frame_done  in  1  completion from the frame writer; pulse or level, rising edge used
- lcd_row1, lcd_row2  out  128  snapshot driven to the frame writer; stable from the cycle before frame_start until the next SELECT
- frame_start  out  1  one-cycle start pulse to the frame writer
- page_sel  out  2  page currently on the LCD (0, 1, 2; 3 never driven)
- busy  out  1  high in START and WAIT
- timeout_err  out  1  set on timeout; cleared on next accepted frame_done or reset

## Operation
- Reset (rst_n low at an edge): state IDLE, lcd_row1/lcd_row2 = sixteen 0x20 bytes each, frame_start 0, page_sel 0, busy 0, timeout_err 0, rotation pointer 0, all counters 0, done edge register 0.
- States:
  - IDLE: if enable, go to SELECT.
  - SELECT (1 cycle): choose the page, latch its rows into lcd_row1/lcd_row2, update page_sel, go to START.
    - Page is 2 if alarm is high.
    - Otherwise, if dwell has expired, advance the pointer (0→1 if page1_en, else stay 0; 1→0), clear dwell, then use the pointer.
    - If the pointer is 1 and page1_en is low, force the pointer to 0.
  - START (1 cycle): frame_start = 1, clear the timeout counter, go to WAIT.
  - WAIT:
    - Rising edge of frame_done (current high, previous-cycle sample low): go to HOLD, clear timeout_err.
    - Otherwise, when the timeout counter reaches TIMEOUT_CYCLES-1: set timeout_err, go to HOLD.
    - enable is ignored in WAIT.
  - HOLD: the refresh counter counts from 0. Exits, in priority order:
    - enable low → IDLE.
    - alarm high and page_sel ≠ 2 → SELECT (preemption).
    - alarm low and page_sel = 2 → SELECT.
    - Refresh counter = REFRESH_CYCLES-1 → SELECT.
- Dwell counter:
  - Counts every cycle outside IDLE and saturates at DWELL_CYCLES-1; reaching that value marks dwell expired.
  - Held at 0 while alarm is high and in IDLE.
  - Advancement is evaluated only in SELECT. A mid-transfer expiry waits for the next SELECT.
- Done edge detection runs in every state. A frame_done held high from a prior frame is never accepted.
- Counters are sized $clog2 of their parameter and never wrap.

## Timing
- enable sampled high in IDLE at edge k: SELECT during cycle k..k+1, lcd_row and page_sel valid after edge k+1, frame_start high for exactly the cycle after edge k+2.
- Accepted frame_done at edge d: state HOLD after d. Next frame_start, absent preemption, is high in the cycle after edge d+REFRESH_CYCLES+2.
- Alarm rising while in HOLD: SELECT one edge later, frame_start two edges after that.
- Alarm rising during START or WAIT: takes effect only after the transfer ends (HOLD exit on its first cycle).
- Timeout: frame_start at cycle s with no done edge gives timeout_err high after edge s+TIMEOUT_CYCLES, state HOLD.
- Reset mid-transfer: all outputs return to their reset values at that edge. frame_start is never re-issued until enable is seen in IDLE.

## Test plan
Bench parameters: DWELL=20, REFRESH=5, TIMEOUT=8. The responder pulses frame_done 3 cycles after frame_start unless stated.
- Reset, then enable=1 with page0 = "HR:072" pattern → frame_start in the third cycle, lcd_row1 equals page0_row1, page_sel=0, busy high in START and WAIT.
- page1_en=1, run 60 cycles → page_sel sequence 0,0,…,1,…,0; switch only at SELECT after ≥20 cycles; every frame_start separated by 1+1+3+5 cycles.
- page1_en=0 → page_sel stays 0 across multiple dwell expiries.
- alarm asserted mid-HOLD on page 1 → page_sel=2 at the next edge's SELECT, frame_start two cycles later. Alarm deasserted → immediate return to the pointer page, dwell restarted from 0.
- Responder silent → timeout_err=1 exactly 8 cycles after frame_start. The next frame completes normally → timeout_err=0.
- frame_done held high permanently → only the first frame is accepted. Later frames time out and timeout_err sets. rst_n low during WAIT → IDLE, all outputs at reset values the following cycle.
